// File: rtl/ahb_matrix_pkg.sv
// Shared AHB bus-matrix definitions: transfer/response encodings and the
// address-phase bundle carried through the input-stage holding register.
package ahb_matrix_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_USER_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef struct packed {
        logic [AHB_ADDR_W-1:0] addr;
        htrans_e               trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
        logic [AHB_USER_W-1:0] auser;
    } ahb_addr_phase_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY never request a transfer.
    function automatic logic is_xfer_trans(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_instage_hold_reg.sv
// Holding register for one AHB address phase plus its valid (pend) flag.
// The user field is loaded as given; the parent ties it to zero when
// AHB_INSTAGE_USER_EN is not defined.
module ahb_instage_hold_reg
    import ahb_matrix_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  ahb_addr_phase_t i_d,
    output ahb_addr_phase_t o_q,
    output logic            o_pend
);

    ahb_addr_phase_t r_hold;
    logic            r_pend;

    // Capture the address phase on load; pend is set by load and dropped on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
            r_pend <= 1'b0;
        end else begin
            if (i_load) begin
                r_hold <= i_d;
            end
            if (i_clear) begin
                r_pend <= 1'b0;
            end else if (i_load) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign o_q    = r_hold;
    assign o_pend = r_pend;

endmodule

// File: rtl/ahb_matrix_input_stage.sv
// AHB bus-matrix input stage: presents the address phase to the decoder
// either live or from a holding register, stalls the master while a held
// transfer waits for its output stage, and returns the decoder response.
// Optional user-signal transport: define AHB_INSTAGE_USER_EN.
module ahb_matrix_input_stage
    import ahb_matrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 32
)
(
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic                  HREADYS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic [USER_WIDTH-1:0] HAUSERS,
    output logic                  HREADYOUTS,
    output logic [1:0]            HRESPS,
    output logic [31:0]           HRDATAS,
    output logic [USER_WIDTH-1:0] HRUSERS,
    output logic                  sel_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [1:0]            trans_in,
    output logic                  write_in,
    output logic [2:0]            size_in,
    output logic [2:0]            burst_in,
    output logic [3:0]            prot_in,
    output logic [USER_WIDTH-1:0] auser_in,
    output logic                  ready_in,
    input  logic                  active_in,
    input  logic                  readyout_in,
    input  logic [1:0]            resp_in,
    input  logic [31:0]           rdata_in,
    input  logic [USER_WIDTH-1:0] ruser_in
);

    logic            w_trans_req;
    logic            w_data_ready;
    logic            w_accept;
    logic            w_load;
    logic            w_pend;
    logic            r_data_phase;
    ahb_addr_phase_t w_live;
    ahb_addr_phase_t w_hold;
    ahb_addr_phase_t w_mux;
    logic            w_unused;

    assign w_trans_req  = HSELS & HREADYS & is_xfer_trans(HTRANSS);
    assign w_data_ready = ~r_data_phase | readyout_in;
    assign w_accept     = (w_pend | w_trans_req) & active_in & w_data_ready;
    // While pend is set HREADYOUTS is low, so the master cannot raise a new request.
    assign w_load       = w_trans_req & ~w_accept;

    // Bundle the live address phase from the master.
    always_comb begin
        w_live       = '0;
        w_live.addr  = AHB_ADDR_W'(HADDRS);
        w_live.trans = htrans_e'(HTRANSS);
        w_live.write = HWRITES;
        w_live.size  = HSIZES;
        w_live.burst = HBURSTS;
        w_live.prot  = HPROTS;
`ifdef AHB_INSTAGE_USER_EN
        w_live.auser = AHB_USER_W'(HAUSERS);
`endif
    end

    ahb_instage_hold_reg u_hold (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_load  (w_load),
        .i_clear (w_accept),
        .i_d     (w_live),
        .o_q     (w_hold),
        .o_pend  (w_pend)
    );

    // Select the held transfer while it is pending, otherwise the live bus.
    always_comb begin
        w_mux = w_pend ? w_hold : w_live;
    end

    assign sel_in   = w_pend | (HSELS & HREADYS);
    assign addr_in  = ADDR_WIDTH'(w_mux.addr);
    assign trans_in = w_mux.trans;
    assign write_in = w_mux.write;
    assign size_in  = w_mux.size;
    assign burst_in = w_mux.burst;
    assign prot_in  = w_mux.prot;
    assign ready_in = w_data_ready;

    // Track whether a transfer routed through the decoder is in its data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_data_phase <= 1'b0;
        end else if (w_accept) begin
            r_data_phase <= 1'b1;
        end else if (readyout_in) begin
            r_data_phase <= 1'b0;
        end
    end

    assign HREADYOUTS = w_pend ? 1'b0 : (r_data_phase ? readyout_in : 1'b1);
    assign HRESPS     = (r_data_phase & ~w_pend) ? resp_in : HRESP_OKAY;
    assign HRDATAS    = rdata_in;

`ifdef AHB_INSTAGE_USER_EN
    assign auser_in = USER_WIDTH'(w_mux.auser);
    assign HRUSERS  = r_data_phase ? ruser_in : '0;
    assign w_unused = 1'b0;
`else
    assign auser_in = '0;
    assign HRUSERS  = '0;
    // User inputs are deliberately ignored in this build.
    assign w_unused = ^{HAUSERS, ruser_in, w_mux.auser};
`endif

endmodule

// File: tb/tb_ahb_matrix_input_stage.sv
// Self-checking bench for ahb_matrix_input_stage: cycle vector table plus
// hand-written reset corner sequences, checked through an expected-value queue.
module tb_ahb_matrix_input_stage;

    typedef struct packed {
        logic        rst;
        logic        hsel;
        logic        hready;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [3:0]  hprot;
        logic        active;
        logic        readyout;
        logic [1:0]  resp;
    } stim_t;

    typedef struct packed {
        logic        hreadyout;
        logic [1:0]  hresp;
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        ready;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS, HREADYS, HWRITES;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic [2:0]  HSIZES, HBURSTS;
    logic [3:0]  HPROTS;
    logic [31:0] HAUSERS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic [31:0] HRDATAS;
    logic [31:0] HRUSERS;
    logic        sel_in;
    logic [31:0] addr_in;
    logic [1:0]  trans_in;
    logic        write_in;
    logic [2:0]  size_in, burst_in;
    logic [3:0]  prot_in;
    logic [31:0] auser_in;
    logic        ready_in;
    logic        active_in, readyout_in;
    logic [1:0]  resp_in;
    logic [31:0] rdata_in;
    logic [31:0] ruser_in;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [31:0] rdata_q[$];

    ahb_matrix_input_stage #(.ADDR_WIDTH(32), .USER_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HREADYS(HREADYS),
        .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HAUSERS(HAUSERS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS),
        .sel_in(sel_in), .addr_in(addr_in), .trans_in(trans_in), .write_in(write_in),
        .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in), .auser_in(auser_in),
        .ready_in(ready_in), .active_in(active_in), .readyout_in(readyout_in),
        .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in)
    );

    always #5 HCLK = ~HCLK;

    function automatic stim_t S(input logic rst, input logic hsel, input logic hready,
                                input logic [1:0] htrans, input logic hwrite,
                                input logic [31:0] haddr, input logic [2:0] hsize,
                                input logic [2:0] hburst, input logic [3:0] hprot,
                                input logic active, input logic readyout,
                                input logic [1:0] resp);
        stim_t s;
        s = '{rst, hsel, hready, htrans, hwrite, haddr, hsize, hburst, hprot,
              active, readyout, resp};
        return s;
    endfunction

    function automatic exp_t E(input logic rdy, input logic [1:0] resp, input logic sel,
                               input logic [1:0] trans, input logic [31:0] addr,
                               input logic write, input logic [2:0] size,
                               input logic [2:0] burst, input logic [3:0] prot,
                               input logic ready);
        exp_t e;
        e = '{rdy, resp, sel, trans, addr, write, size, burst, prot, ready};
        return e;
    endfunction

    task automatic drive(input stim_t s, input exp_t e, input logic [31:0] rdata);
        HRESET      = s.rst;
        HSELS       = s.hsel;
        HREADYS     = s.hready;
        HTRANSS     = s.htrans;
        HWRITES     = s.hwrite;
        HADDRS      = s.haddr;
        HSIZES      = s.hsize;
        HBURSTS     = s.hburst;
        HPROTS      = s.hprot;
        active_in   = s.active;
        readyout_in = s.readyout;
        resp_in     = s.resp;
        rdata_in    = rdata;
        sb_q.push_back(e);
        rdata_q.push_back(rdata);
    endtask

    task automatic check(input int idx);
        exp_t        exp_v;
        exp_t        act;
        logic [31:0] exp_rd;
        if (sb_q.size() == 0 || rdata_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL step%0d scoreboard: queue empty, expected an entry", idx);
            return;
        end
        exp_v  = sb_q.pop_front();
        exp_rd = rdata_q.pop_front();
        act = '{HREADYOUTS, HRESPS, sel_in, trans_in, addr_in, write_in,
                size_in, burst_in, prot_in, ready_in};
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL step%0d core: got %h expected %h", idx, act, exp_v);
        end
        n_cmp++;
`ifdef AHB_INSTAGE_USER_EN
        if (HRDATAS !== exp_rd) begin
            n_fail++;
            $display("FAIL step%0d rdata: got %h expected %h", idx, HRDATAS, exp_rd);
        end
`else
        if ({HRDATAS, HRUSERS, auser_in} !== {exp_rd, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL step%0d rdata/user: got %h/%h/%h expected %h/0/0",
                     idx, HRDATAS, HRUSERS, auser_in, exp_rd);
        end
`endif
    endtask

    task automatic cycle(input int idx, input stim_t s, input exp_t e);
        @(posedge HCLK);
        #1;
        drive(s, e, 32'hC0DE_0000 | 32'(idx));
        @(negedge HCLK);
        check(idx);
    endtask

    vec_t vecs[23];

    initial begin
        HAUSERS  = 32'hDEAD_BEEF;
        ruser_in = 32'h1234_5678;
        HRESET = 1'b1; HSELS = 1'b1; HREADYS = 1'b1; HTRANSS = 2'b00; HWRITES = 1'b0;
        HADDRS = '0; HSIZES = '0; HBURSTS = '0; HPROTS = '0;
        active_in = 1'b0; readyout_in = 1'b1; resp_in = 2'b00; rdata_in = '0;

        // reset, with a NONSEQ request present that must not be captured
        vecs[0]  = '{S(1,1,1,0,0,32'h0,0,0,0,0,1,0),      E(1,0,1,0,32'h0,0,0,0,0,1)};
        vecs[1]  = '{S(1,1,1,2,0,32'h1000,0,0,0,0,1,0),   E(1,0,1,2,32'h1000,0,0,0,0,1)};
        vecs[2]  = '{S(0,0,1,0,0,32'h0,0,0,0,0,1,0),      E(1,0,0,0,32'h0,0,0,0,0,1)};
        // zero-wait write, then back-to-back read accepted as the data phase ends
        vecs[3]  = '{S(0,1,1,2,1,32'h1000,2,0,3,1,1,0),   E(1,0,1,2,32'h1000,1,2,0,3,1)};
        vecs[4]  = '{S(0,1,0,2,0,32'h2000,0,0,0,1,0,0),   E(0,0,0,2,32'h2000,0,0,0,0,0)};
        vecs[5]  = '{S(0,1,1,2,0,32'h2000,0,0,0,1,1,0),   E(1,0,1,2,32'h2000,0,0,0,0,1)};
        vecs[6]  = '{S(0,0,1,0,0,32'h0,0,0,0,1,1,0),      E(1,0,0,0,32'h0,0,0,0,0,1)};
        vecs[7]  = '{S(0,0,1,0,0,32'h0,0,0,0,1,0,0),      E(1,0,0,0,32'h0,0,0,0,0,1)};
        // held read: captured, stalled two cycles, accepted when active_in rises
        vecs[8]  = '{S(0,1,1,2,0,32'h40,1,3,2,0,1,0),     E(1,0,1,2,32'h40,0,1,3,2,1)};
        vecs[9]  = '{S(0,1,0,2,1,32'h80,2,0,0,0,1,0),     E(0,0,1,2,32'h40,0,1,3,2,1)};
        vecs[10] = '{S(0,1,0,2,1,32'h80,2,0,0,0,1,0),     E(0,0,1,2,32'h40,0,1,3,2,1)};
        vecs[11] = '{S(0,1,0,2,1,32'h80,2,0,0,1,1,0),     E(0,0,1,2,32'h40,0,1,3,2,1)};
        // data phase of the held read with three wait states
        vecs[12] = '{S(0,1,0,2,1,32'h80,2,0,0,1,0,0),     E(0,0,0,2,32'h80,1,2,0,0,0)};
        vecs[13] = '{S(0,1,0,2,1,32'h80,2,0,0,1,0,0),     E(0,0,0,2,32'h80,1,2,0,0,0)};
        vecs[14] = '{S(0,1,0,2,1,32'h80,2,0,0,1,0,0),     E(0,0,0,2,32'h80,1,2,0,0,0)};
        vecs[15] = '{S(0,1,1,2,1,32'h80,2,0,0,1,1,0),     E(1,0,1,2,32'h80,1,2,0,0,1)};
        vecs[16] = '{S(0,0,1,0,0,32'h0,0,0,0,1,1,0),      E(1,0,0,0,32'h0,0,0,0,0,1)};
        // two-cycle ERROR response, then ERROR ignored outside a data phase
        vecs[17] = '{S(0,1,1,2,0,32'h100,0,0,0,1,1,0),    E(1,0,1,2,32'h100,0,0,0,0,1)};
        vecs[18] = '{S(0,0,0,0,0,32'h0,0,0,0,1,0,1),      E(0,1,0,0,32'h0,0,0,0,0,0)};
        vecs[19] = '{S(0,0,1,0,0,32'h0,0,0,0,1,1,1),      E(1,1,0,0,32'h0,0,0,0,0,1)};
        vecs[20] = '{S(0,0,1,0,0,32'h0,0,0,0,1,1,1),      E(1,0,0,0,32'h0,0,0,0,0,1)};
        // BUSY with no output stage: passes through, never captured
        vecs[21] = '{S(0,1,1,1,0,32'h600,0,0,0,0,1,0),    E(1,0,1,1,32'h600,0,0,0,0,1)};
        vecs[22] = '{S(0,0,1,0,0,32'h0,0,0,0,0,1,0),      E(1,0,0,0,32'h0,0,0,0,0,1)};

        for (int i = 0; i < 23; i++) begin
            cycle(i, vecs[i].s, vecs[i].e);
        end

        // reset while a transfer is held
        cycle(100, S(0,1,1,2,0,32'h300,0,0,0,0,1,0), E(1,0,1,2,32'h300,0,0,0,0,1));
        cycle(101, S(1,0,0,0,0,32'h0,0,0,0,0,1,0),   E(0,0,1,2,32'h300,0,0,0,0,1));
        cycle(102, S(0,0,1,0,0,32'h0,0,0,0,0,1,0),   E(1,0,0,0,32'h0,0,0,0,0,1));
        cycle(103, S(0,1,1,0,0,32'h500,0,0,0,0,1,0), E(1,0,1,0,32'h500,0,0,0,0,1));

        // reset during a stalled data phase
        cycle(110, S(0,1,1,2,1,32'h700,0,0,0,1,1,0), E(1,0,1,2,32'h700,1,0,0,0,1));
        cycle(111, S(1,0,0,0,0,32'h0,0,0,0,1,0,0),   E(0,0,0,0,32'h0,0,0,0,0,0));
        cycle(112, S(0,0,1,0,0,32'h0,0,0,0,1,0,0),   E(1,0,0,0,32'h0,0,0,0,0,1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
